stmt_check_arbiter: RTL

Shares one declaration-checking FSM between NREQ character-stream requesters. Each requester sends one C-style `int` declaration statement per grant, ending in `;`. The block grants requesters round-robin at statement granularity and feeds the granted stream into the shared checker. For each statement it reports one verdict tagged with the source index. It sits between the per-source character front ends and the result collector.

---
 rtl/stmt_check_arbiter_pkg.sv | 42 ++++
 rtl/stmt_check_arbiter_decl_fsm.sv | 60 ++++++
 rtl/stmt_check_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stmt_check_arbiter_pkg.sv
// stmt_check_arbiter_pkg: shared encodings, character constants and helpers for the statement arbiter.
package stmt_check_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SEMI  = 8'h3B;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_T     = 8'h74;

    // KW_* walk the leading keyword; ID_I/ID_IN/ID_INT catch an identifier spelled exactly `int`.
    localparam logic [3:0] CK_START  = 4'd0;
    localparam logic [3:0] CK_KW_I   = 4'd1;
    localparam logic [3:0] CK_KW_IN  = 4'd2;
    localparam logic [3:0] CK_KW_INT = 4'd3;
    localparam logic [3:0] CK_LIST   = 4'd4;
    localparam logic [3:0] CK_ID_I   = 4'd5;
    localparam logic [3:0] CK_ID_IN  = 4'd6;
    localparam logic [3:0] CK_ID_INT = 4'd7;
    localparam logic [3:0] CK_ID     = 4'd8;
    localparam logic [3:0] CK_TAIL   = 4'd9;
    localparam logic [3:0] CK_ERR    = 4'd10;

    typedef struct packed {
        logic [1:0] src;
        logic       ok;
        logic       abort;
    } verdict_t;

    function automatic logic is_id_start(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) || c == 8'h5F;
    endfunction

    function automatic logic is_id_char(input logic [7:0] c);
        return is_id_start(c) || (c >= 8'h30 && c <= 8'h39);
    endfunction

endpackage

// File: rtl/stmt_check_arbiter_decl_fsm.sv
// decl_fsm: incremental checker for one `int` declaration, advancing one character per enabled cycle.
module decl_fsm
    import stmt_check_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] ch,
    output logic       err,
    output logic       done_ok
);

    logic [3:0] r_st;
    logic       r_err;
    logic [3:0] w_nxt;
    logic [3:0] w_after_id;
    logic       w_id_start;
    logic       w_id_char;
    logic       w_can_end;

    assign w_id_start = is_id_start(ch);
    assign w_id_char  = is_id_char(ch);
    assign w_after_id = (ch == CH_SPACE) ? CK_TAIL :
                        (ch == CH_COMMA) ? CK_LIST :
                        (ch == CH_SEMI)  ? CK_START : CK_ERR;
    assign w_can_end  = r_st == CK_ID_I || r_st == CK_ID_IN || r_st == CK_ID || r_st == CK_TAIL;

    always_comb begin
        w_nxt = CK_ERR;
        case (r_st)
            CK_START:  w_nxt = (ch == CH_SPACE) ? CK_START : (ch == CH_I) ? CK_KW_I : CK_ERR;
            CK_KW_I:   w_nxt = (ch == CH_N) ? CK_KW_IN : CK_ERR;
            CK_KW_IN:  w_nxt = (ch == CH_T) ? CK_KW_INT : CK_ERR;
            CK_KW_INT: w_nxt = (ch == CH_SPACE) ? CK_LIST : CK_ERR;
            CK_LIST:   w_nxt = (ch == CH_SPACE) ? CK_LIST : (ch == CH_I) ? CK_ID_I : w_id_start ? CK_ID : CK_ERR;
            CK_ID_I:   w_nxt = (ch == CH_N) ? CK_ID_IN : w_id_char ? CK_ID : w_after_id;
            CK_ID_IN:  w_nxt = (ch == CH_T) ? CK_ID_INT : w_id_char ? CK_ID : w_after_id;
            CK_ID_INT: w_nxt = w_id_char ? CK_ID : CK_ERR;
            CK_ID:     w_nxt = w_id_char ? CK_ID : w_after_id;
            CK_TAIL:   w_nxt = (ch == CH_SPACE) ? CK_TAIL : (ch == CH_COMMA) ? CK_LIST :
                               (ch == CH_SEMI) ? CK_START : CK_ERR;
            default:   w_nxt = CK_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            r_st  <= CK_START;
            r_err <= 1'b0;
        end else if (en) begin
            r_st  <= w_nxt;
            r_err <= r_err | (w_nxt == CK_ERR);
        end
    end

    assign err     = r_err;
    assign done_ok = ch == CH_SEMI && w_can_end && !r_err;

endmodule

// File: rtl/stmt_check_arbiter.sv
// stmt_check_arbiter: round-robin, statement-granular sharing of one declaration checker among NREQ streams.
module stmt_check_arbiter
    import stmt_check_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16,
    parameter int MAXLEN  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_char,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [1:0]        res_src,
    output logic              res_ok,
    output logic              res_abort
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(MAXLEN + 1);

    logic [1:0]    r_state;
    logic [1:0]    r_grant;
    logic [1:0]    r_last;
    logic [SW-1:0] r_stall;
    logic [LW-1:0] r_len;
    logic          r_res_valid;
    verdict_t      r_res;

    logic          w_found;
    logic [1:0]    w_pick;
    logic [1:0]    w_idx;
    logic          w_gvalid;
    logic          w_accept;
    logic [7:0]    w_ch;
    logic          w_is_semi;
    logic          w_done_ok;
    logic          w_err;
    logic          w_ok;
    logic [SW-1:0] w_stall_nxt;
    logic [LW-1:0] w_len_nxt;

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = 2'((int'(r_last) + k) % NREQ);
            if (!w_found && |(req_valid & (NREQ'(1) << w_idx))) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_gvalid    = |(req_valid & (NREQ'(1) << r_grant));
    assign w_ch        = 8'(req_char >> {r_grant, 3'b000});
    assign w_accept    = r_state == ST_STREAM && w_gvalid;
    assign w_is_semi   = w_ch == CH_SEMI;
    assign w_ok        = w_done_ok & ~w_err;
    assign w_stall_nxt = r_stall + 1'b1;
    assign w_len_nxt   = r_len + 1'b1;
    assign req_ready   = (r_state == ST_STREAM) ? (NREQ'(1) << r_grant) : '0;

    decl_fsm u_decl_fsm (
        .clk     (clk),
        .reset   (reset),
        .en      (w_accept),
        .clr     (r_state == ST_DONE),
        .ch      (w_ch),
        .err     (w_err),
        .done_ok (w_done_ok)
    );

    // A ';' is an accept, never a stall, so it always beats an expiring stall counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_last      <= 2'(NREQ - 1);
            r_stall     <= '0;
            r_len       <= '0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        r_stall <= '0;
                        r_len   <= w_len_nxt;
                        if (w_is_semi || w_len_nxt == LW'(MAXLEN)) begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                            r_res       <= '{src: r_grant, ok: w_is_semi & w_ok, abort: ~w_is_semi};
                        end
                    end else if (w_stall_nxt == SW'(TIMEOUT)) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                        r_res       <= '{src: r_grant, ok: 1'b0, abort: 1'b1};
                    end else begin
                        r_stall <= w_stall_nxt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_last  <= r_grant;
                    r_stall <= '0;
                    r_len   <= '0;
                    r_res   <= '{src: r_grant, ok: 1'b0, abort: 1'b0};
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_src   = r_res.src;
    assign res_ok    = r_res.ok;
    assign res_abort = r_res.abort;

endmodule
